// File: rtl/alu_muldiv.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers (1 bit per cycle).
// Optional divide-by-zero status output enabled by defining ALU_MULDIV_DIV0_FLAG_EN.
module alu_muldiv #(
  parameter int NB_DATA   = 32,
  parameter int NB_ALU_OP = 6
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_valid,
  input  logic [NB_ALU_OP-1:0] i_op,
  input  logic [NB_DATA-1:0]   i_dato_a,
  input  logic [NB_DATA-1:0]   i_dato_b,
  output logic [NB_DATA-1:0]   o_data,
  output logic                 o_busy,
  output logic                 o_stall,
  output logic                 o_done,
  output logic [NB_DATA-1:0]   o_hi,
  output logic [NB_DATA-1:0]   o_lo,
  output logic [1:0]           o_dbg_state
`ifdef ALU_MULDIV_DIV0_FLAG_EN
  ,
  output logic                 o_div_by_zero
`endif
);

  localparam int NB_CNT = $clog2(NB_DATA + 1);

  localparam logic [NB_ALU_OP-1:0] OP_MFHI  = NB_ALU_OP'(6'b010000);
  localparam logic [NB_ALU_OP-1:0] OP_MTHI  = NB_ALU_OP'(6'b010001);
  localparam logic [NB_ALU_OP-1:0] OP_MFLO  = NB_ALU_OP'(6'b010010);
  localparam logic [NB_ALU_OP-1:0] OP_MTLO  = NB_ALU_OP'(6'b010011);
  localparam logic [NB_ALU_OP-1:0] OP_MULT  = NB_ALU_OP'(6'b011000);
  localparam logic [NB_ALU_OP-1:0] OP_MULTU = NB_ALU_OP'(6'b011001);
  localparam logic [NB_ALU_OP-1:0] OP_DIV   = NB_ALU_OP'(6'b011010);
  localparam logic [NB_ALU_OP-1:0] OP_DIVU  = NB_ALU_OP'(6'b011011);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  state_t              state;
  logic [NB_CNT-1:0]   count;
  logic [NB_DATA-1:0]  acc;    // product high half / partial remainder
  logic [NB_DATA-1:0]  mq;     // multiplier / dividend-then-quotient
  logic [NB_DATA-1:0]  opnd;   // |multiplicand| or |divisor|
  logic                neg_q;
  logic                neg_r;
  logic                div0;
  logic                is_div;
  logic [NB_DATA-1:0]  hi;
  logic [NB_DATA-1:0]  lo;
  logic                done;

  logic                is_muldiv;
  logic                is_listed;
  logic                op_signed;
  logic                a_neg;
  logic                b_neg;
  logic [NB_DATA:0]    mul_sum;
  logic [NB_DATA:0]    div_shift;
  logic                div_ge;
  logic [NB_DATA-1:0]  div_diff;
  logic [2*NB_DATA-1:0] prod_mag;
  logic [2*NB_DATA-1:0] prod_fix;
  logic [NB_DATA-1:0]  q_fix;
  logic [NB_DATA-1:0]  r_fix;

  always_comb begin
    is_muldiv = (i_op == OP_MULT) || (i_op == OP_MULTU) ||
                (i_op == OP_DIV)  || (i_op == OP_DIVU);
    is_listed = is_muldiv || (i_op == OP_MFHI) || (i_op == OP_MTHI) ||
                (i_op == OP_MFLO) || (i_op == OP_MTLO);
    op_signed = ~i_op[0];
    a_neg     = op_signed & i_dato_a[NB_DATA-1];
    b_neg     = op_signed & i_dato_b[NB_DATA-1];

    mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
    div_shift = {acc, mq[NB_DATA-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_diff  = div_shift[NB_DATA-1:0] - opnd;

    prod_mag  = {acc, mq};
    prod_fix  = neg_q ? -prod_mag : prod_mag;
    // A zero divisor leaves |dividend| in acc, so the remainder fix restores the dividend.
    q_fix     = div0 ? '1 : (neg_q ? -mq : mq);
    r_fix     = neg_r ? -acc : acc;
  end

  // Handshake: an op is taken when i_valid is high at an edge while IDLE. While busy,
  // every listed op raises o_stall and is dropped; the requester holds it and retries.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state  <= ST_IDLE;
      count  <= '0;
      acc    <= '0;
      mq     <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      is_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_valid && is_muldiv) begin
            acc    <= '0;
            mq     <= a_neg ? -i_dato_a : i_dato_a;
            opnd   <= b_neg ? -i_dato_b : i_dato_b;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div0   <= (i_dato_b == '0);
            is_div <= i_op[1];
            count  <= NB_CNT'(NB_DATA);
            state  <= i_op[1] ? ST_DIV : ST_MUL;
          end else if (i_valid && (i_op == OP_MTHI)) begin
            hi <= i_dato_a;
          end else if (i_valid && (i_op == OP_MTLO)) begin
            lo <= i_dato_a;
          end
        end
        ST_MUL: begin
          if (count != '0) begin
            acc   <= mul_sum[NB_DATA:1];
            mq    <= {mul_sum[0], mq[NB_DATA-1:1]};
            count <= count - NB_CNT'(1);
          end else begin
            state <= ST_FIX;
          end
        end
        ST_DIV: begin
          if (count != '0) begin
            acc   <= div_ge ? div_diff : div_shift[NB_DATA-1:0];
            mq    <= {mq[NB_DATA-2:0], div_ge};
            count <= count - NB_CNT'(1);
          end else begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (is_div) begin
            hi <= r_fix;
            lo <= q_fix;
          end else begin
            hi <= prod_fix[2*NB_DATA-1:NB_DATA];
            lo <= prod_fix[NB_DATA-1:0];
          end
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_MULDIV_DIV0_FLAG_EN
  logic dz_flag;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      dz_flag <= 1'b0;
    end else if ((state == ST_IDLE) && i_valid && is_muldiv) begin
      dz_flag <= 1'b0;
    end else if ((state == ST_FIX) && is_div && div0) begin
      dz_flag <= 1'b1;
    end
  end

  assign o_div_by_zero = dz_flag;
`endif

  assign o_busy      = (state != ST_IDLE);
  assign o_stall     = i_valid & is_listed & o_busy;
  assign o_done      = done;
  assign o_hi        = hi;
  assign o_lo        = lo;
  assign o_dbg_state = state;
  assign o_data      = (i_op == OP_MFHI) ? hi :
                       (i_op == OP_MFLO) ? lo : '0;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed, table-driven bench for alu_muldiv: result vectors plus hand-written
// sequences for reset abort, stalls, HI/LO moves and back-to-back issue.
module tb_alu_muldiv;

  localparam int NB_DATA   = 32;
  localparam int NB_ALU_OP = 6;
  localparam int LATENCY   = NB_DATA + 2;

  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MTLO  = 6'b010011;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_ADD   = 6'b100000;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 i_valid;
  logic [NB_ALU_OP-1:0] i_op;
  logic [NB_DATA-1:0]   i_dato_a;
  logic [NB_DATA-1:0]   i_dato_b;
  logic [NB_DATA-1:0]   o_data;
  logic                 o_busy;
  logic                 o_stall;
  logic                 o_done;
  logic [NB_DATA-1:0]   o_hi;
  logic [NB_DATA-1:0]   o_lo;
  logic [1:0]           o_dbg_state;
`ifdef ALU_MULDIV_DIV0_FLAG_EN
  logic                 o_div_by_zero;
`endif

  always #5 clk = ~clk;

  alu_muldiv #(.NB_DATA(NB_DATA), .NB_ALU_OP(NB_ALU_OP)) dut (
    .i_clock     (clk),
    .i_reset_n   (reset_n),
    .i_valid     (i_valid),
    .i_op        (i_op),
    .i_dato_a    (i_dato_a),
    .i_dato_b    (i_dato_b),
    .o_data      (o_data),
    .o_busy      (o_busy),
    .o_stall     (o_stall),
    .o_done      (o_done),
    .o_hi        (o_hi),
    .o_lo        (o_lo),
    .o_dbg_state (o_dbg_state)
`ifdef ALU_MULDIV_DIV0_FLAG_EN
    ,
    .o_div_by_zero (o_div_by_zero)
`endif
  );

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t        vecs[12];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one op for exactly one edge; returns #1 after that edge.
  task automatic start_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    i_valid  = 1'b1;
    i_op     = op;
    i_dato_a = a;
    i_dato_b = b;
    @(posedge clk);
    #1;
    i_valid  = 1'b0;
    i_op     = OP_ADD;
  endtask

  // Counts edges after the accepting edge until o_done is seen, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while ((o_done !== 1'b1) && (lat < 100)) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int seen;
    int stalls;
    logic [31:0] exp_lo;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFD, 32'd7,        32'h00000006, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{OP_DIVU,  32'h80000000, 32'h10,       32'h00000000, 32'h08000000, 1'b0};
    vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{OP_DIVU,  32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[8]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[9]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[10] = '{OP_MULT,  32'd3,        32'd5,        32'h00000000, 32'd15,       1'b0};
    vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0};

    // Clock/reset
    reset_n  = 1'b0;
    i_valid  = 1'b0;
    i_op     = OP_ADD;
    i_dato_a = '0;
    i_dato_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", o_hi, 32'h0);
    check("reset_lo", o_lo, 32'h0);
    check("reset_busy", 32'(o_busy), 32'h0);
    check("reset_done", 32'(o_done), 32'h0);
    check("reset_state", 32'(o_dbg_state), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset abort after 10 iterations
    @(negedge clk);
    start_op(OP_MULT, 32'd3, 32'd5);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(o_busy), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (o_done) seen++;
    end
    check("abort_done_pulses", 32'(seen), 32'h0);
    check("abort_hi", o_hi, 32'h0);
    check("abort_lo", o_lo, 32'h0);

    // Result vectors
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp_q.push_back(vecs[i].lo);
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy", i), 32'(o_busy), 32'h1);
      i_dato_a = $urandom;
      i_dato_b = $urandom_range(0, 255);
      wait_done(lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(LATENCY));
      check($sformatf("v%0d_busy_at_done", i), 32'(o_busy), 32'h0);
      check($sformatf("v%0d_hi", i), o_hi, vecs[i].hi);
      exp_lo = exp_q.pop_front();
      check($sformatf("v%0d_lo", i), o_lo, exp_lo);
      i_op = OP_MFHI;
      #1;
      check($sformatf("v%0d_mfhi", i), o_data, vecs[i].hi);
`ifdef ALU_MULDIV_DIV0_FLAG_EN
      check($sformatf("v%0d_div0_flag", i), 32'(o_div_by_zero), 32'(vecs[i].dz));
`endif
      @(posedge clk);
      #1;
      i_op = OP_ADD;
      check($sformatf("v%0d_done_pulse", i), 32'(o_done), 32'h0);
    end

    // MTHI/MTLO then MFHI/MFLO
    @(negedge clk);
    start_op(OP_MTHI, 32'hCAFEF00D, 32'h0);
    i_valid = 1'b1;
    i_op    = OP_MFHI;
    #1;
    check("mfhi_data", o_data, 32'hCAFEF00D);
    check("mthi_no_done", 32'(o_done), 32'h0);
    check("mthi_no_busy", 32'(o_busy), 32'h0);
    i_valid = 1'b0;
    @(negedge clk);
    start_op(OP_MTLO, 32'h13572468, 32'h0);
    i_op = OP_MFLO;
    #1;
    check("mflo_data", o_data, 32'h13572468);

    // Unlisted op: no stall, zero data, nothing starts
    @(negedge clk);
    i_valid = 1'b1;
    i_op    = OP_ADD;
    #1;
    check("unlisted_stall", 32'(o_stall), 32'h0);
    check("unlisted_data", o_data, 32'h0);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    check("unlisted_busy", 32'(o_busy), 32'h0);

    // MFLO held while DIV 100/7 is busy, retried in the done cycle
    @(negedge clk);
    start_op(OP_DIVU, 32'd100, 32'd7);
    i_valid = 1'b1;
    i_op    = OP_MFLO;
    stalls  = 0;
    lat     = 0;
    while ((o_done !== 1'b1) && (lat < 100)) begin
      if (o_stall) stalls++;
      i_dato_a = $urandom;
      @(posedge clk);
      #1;
      lat++;
    end
    check("stall_cycles", 32'(stalls), 32'(LATENCY));
    check("stall_latency", 32'(lat), 32'(LATENCY));
    check("stall_at_done", 32'(o_stall), 32'h0);
    check("retry_mflo", o_data, 32'd14);
    check("retry_hi", o_hi, 32'd2);
    i_valid = 1'b0;

    // MTHI during a busy MULT is dropped; next MULT issued in the done cycle
    @(negedge clk);
    start_op(OP_MULT, 32'd2, 32'd4);
    i_valid  = 1'b1;
    i_op     = OP_MTHI;
    i_dato_a = 32'hDEADBEEF;
    wait_done(lat);
    i_valid = 1'b0;
    check("b2b_first_latency", 32'(lat), 32'(LATENCY));
    check("b2b_first_hi", o_hi, 32'h0);
    check("b2b_first_lo", o_lo, 32'd8);
    start_op(OP_MULT, 32'd3, 32'd5);
    check("b2b_second_busy", 32'(o_busy), 32'h1);
    wait_done(lat);
    check("b2b_second_latency", 32'(lat), 32'(LATENCY));
    check("b2b_second_lo", o_lo, 32'd15);
    check("b2b_second_hi", o_hi, 32'h0);
`ifdef ALU_MULDIV_DIV0_FLAG_EN
    check("div0_flag_clear", 32'(o_div_by_zero), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Iterative multiply/divide unit with architectural HI/LO registers, placed in the execute stage beside the combinational ALU. Handles MIPS MULT/MULTU/DIV/DIVU through a start/busy/done handshake, plus MFHI/MFLO/MTHI/MTLO. Width is parametrised. Uses one shift-add/shift-subtract datapath, one bit per cycle. Raises a stall request to the pipeline while an operation is in flight.

Parameters:
NB_DATA, 32, operand/HI/LO width (even, >=4)
NB_ALU_OP, 6, width of i_op (MIPS funct code)

Ports:
i_clock  in  1  clock, rising edge
i_reset_n  in  1  synchronous active-low reset
i_valid  in  1  i_op/i_dato_a/i_dato_b valid this cycle
i_op  in  NB_ALU_OP  funct: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011
i_dato_a  in  NB_DATA  rs operand (multiplicand/dividend; source for MTHI/MTLO)
i_dato_b  in  NB_DATA  rt operand (multiplier/divisor)
o_data  out  NB_DATA  HI for MFHI, LO for MFLO, else 0 (combinational from i_op)
o_busy  out  1  mul/div in flight
o_stall  out  1  i_valid & any listed op & o_busy (combinational)
o_done  out  1  one-cycle pulse: HI/LO just updated by mul/div
o_hi  out  NB_DATA  HI register
o_lo  out  NB_DATA  LO register

Behaviour:
- Reset (i_reset_n=0 at an edge): state IDLE; HI, LO, counter, internal regs = 0; o_busy=0, o_done=0. Reset also aborts any operation in flight. No partial result reaches HI/LO.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE accepts i_valid at an edge:
  - MULT/MULTU -> MUL; DIV/DIVU -> DIV.
  - Latch absolute values for signed ops and the result-sign bits. Counter = NB_DATA.
- MUL/DIV: one iteration per edge. Counter decrements. After NB_DATA iterations -> FIX.
  - MUL: 2*NB_DATA-bit shift-add.
  - DIV: restoring divide.
- FIX, one edge:
  - Apply sign correction and write HI/LO. o_done=1 in the following cycle.
  - Return to IDLE. o_busy deasserts in that same cycle.
- Latency: o_done is high in the cycle after the (NB_DATA+2)th edge counted from the accepting edge. o_busy is high from the cycle after acceptance through the cycle before o_done.
- A new mul/div may be accepted in the o_done cycle.
- MULT: {HI,LO} = signed product. MULTU: unsigned product.
- DIV: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend. DIVU: unsigned.
- Signed overflow (most-negative / -1): LO = most-negative, HI = 0.
- Divide by zero, signed or unsigned: LO = all ones, HI = dividend unchanged. Takes full latency and raises o_done.
- MTHI/MTLO in IDLE: written at the accepting edge, visible next cycle. No o_done, no busy.
- MFHI/MFLO: o_data is valid the same cycle when not busy. If a write to the same register is accepted at that edge, o_data shows the old value.
- Any listed op with i_valid while busy: o_stall=1, op ignored. The requester must hold and retry. In-flight inputs are latched, so input changes while busy have no effect.
- Unlisted i_op with i_valid: ignored, no stall, o_data=0.

Optional Feature:
Macro ALU_MULDIV_DIV0_FLAG_EN.
- Defined: adds output o_div_by_zero (1 bit). It is set at the FIX edge of a DIV/DIVU with divisor 0, so it is high in the o_done cycle. It stays high until the next accepted mul/div or reset. HI/LO results are unchanged from the default behaviour.
- Undefined: the port is absent and there is no extra logic.

Test Plan:
- Reset then idle: o_hi=o_lo=0, o_busy=o_done=0. Apply reset mid-MULT (after 10 iterations): HI/LO stay 0 and o_done never pulses.
- MULT a=0xFFFFFFFD (-3), b=7 -> o_done exactly 34 edges after acceptance; HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU with the same operands -> HI=0x00000006, LO=0xFFFFFFEB.
- DIV a=-7, b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU a=0x80000000, b=0x10 -> LO=0x08000000, HI=0.
- DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x1234; with ALU_MULDIV_DIV0_FLAG_EN, o_div_by_zero=1.
- MFLO issued while DIV is busy -> o_stall=1 every busy cycle, op ignored. Retry in the o_done cycle -> o_data=the new LO.
- MTHI 0xCAFEF00D then MFHI on the next cycle -> o_data=0xCAFEF00D, o_done stays 0. Then MULT 3x5 accepted back-to-back in the o_done cycle of the previous MULT -> LO=15.
